// File: rtl/conv_frame_ctrl_if.sv
// conv_frame_ctrl_if: source, datapath and sink stream signals of the convolution frame sequencer.
interface conv_frame_ctrl_if #(parameter int W = 30);
  logic src_valid, src_ready;
  logic [W-1:0] src_data;
  logic conv_valid, conv_ready;
  logic [W-1:0] conv_data;
  logic res_valid, res_ready;
  logic [W-1:0] res_data;
  logic out_valid, out_ready, out_sof, out_eof;
  logic [W-1:0] out_data;
  modport master(
    input src_valid, src_data, conv_ready, res_valid, res_data, out_ready,
    output src_ready, conv_valid, conv_data, res_ready, out_valid, out_data, out_sof, out_eof
  );
  modport slave(
    output src_valid, src_data, conv_ready, res_valid, res_data, out_ready,
    input src_ready, conv_valid, conv_data, res_ready, out_valid, out_data, out_sof, out_eof
  );
endinterface

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer around a 3x3 line-buffer convolution datapath; CONV_CTRL_STATS_EN adds frame/stall counters.
module conv_frame_ctrl #(
  parameter int W = 30,
  parameter int WIDTH = 320,
  parameter int HEIGHT = 240,
  parameter logic [W-1:0] BORDER_VALUE = '0
) (
  input  logic clk,
  input  logic reset,
  conv_frame_ctrl_if.master bus,
  output logic busy,
  output logic frame_done
`ifdef CONV_CTRL_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [31:0] stall_cycles
`endif
);
  localparam int CW = $clog2(WIDTH * HEIGHT + WIDTH + 2);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] in_cnt, fl_cnt, disc_cnt, row, col;
  logic discard, last_col, last_row, border, in_hs, res_hs, out_hs;
  always_comb begin
    discard = disc_cnt != '0;
    last_col = col == CW'(WIDTH - 1);
    last_row = row == CW'(HEIGHT - 1);
    border = row == '0 || last_row || col == '0 || last_col;
    bus.src_ready = state == STREAM && bus.conv_ready;
    bus.conv_valid = state == STREAM ? bus.src_valid : state == FLUSH;
    bus.conv_data = state == STREAM ? bus.src_data : '0;
    // The result side is stateless pass-through once warm-up results are discarded.
    bus.res_ready = !reset && (discard || bus.out_ready);
    bus.out_valid = !reset && !discard && bus.res_valid;
    bus.out_data = border ? BORDER_VALUE : bus.res_data;
    bus.out_sof = bus.out_valid && row == '0 && col == '0;
    bus.out_eof = bus.out_valid && last_row && last_col;
    in_hs = bus.conv_valid && bus.conv_ready;
    res_hs = bus.res_valid && bus.res_ready;
    out_hs = bus.out_valid && bus.out_ready;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      in_cnt <= '0;
      fl_cnt <= '0;
      row <= '0;
      col <= '0;
      disc_cnt <= CW'(WIDTH + 1);
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_hs && bus.out_eof;
      if (discard && res_hs) disc_cnt <= disc_cnt - CW'(1);
      if (out_hs) begin
        col <= last_col ? '0 : col + CW'(1);
        row <= last_col ? (last_row ? '0 : row + CW'(1)) : row;
      end
      case (state)
        IDLE: if (bus.src_valid) begin
          state <= STREAM;
          disc_cnt <= CW'(WIDTH + 1);
        end
        STREAM: if (in_hs) begin
          in_cnt <= in_cnt == CW'(WIDTH * HEIGHT - 1) ? '0 : in_cnt + CW'(1);
          if (in_cnt == CW'(WIDTH * HEIGHT - 1)) state <= FLUSH;
        end
        FLUSH: if (in_hs) begin
          fl_cnt <= fl_cnt == CW'(WIDTH) ? '0 : fl_cnt + CW'(1);
          if (fl_cnt == CW'(WIDTH)) state <= DRAIN;
        end
        default: if (frame_done) state <= IDLE;
      endcase
    end
  end
`ifdef CONV_CTRL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
      stall_cycles <= '0;
    end else begin
      frame_count <= frame_count + 16'(frame_done);
      if (bus.out_valid && !bus.out_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: directed bench for conv_frame_ctrl with a 1-cycle registered identity datapath model.
module tb_conv_frame_ctrl;
  localparam int W = 30;
  localparam int WIDTH = 4;
  localparam int HEIGHT = 3;
  localparam int N = WIDTH * HEIGHT;
  localparam logic [W-1:0] BV = 30'h3FF;
  typedef struct {
    logic [W-1:0] px;
    logic [W-1:0] od;
    logic sof;
    logic eof;
  } vec_t;
  vec_t vec[N];
  logic clk = 0, reset = 1, busy, frame_done, tog = 0, phase = 0;
`ifdef CONV_CTRL_STATS_EN
  logic [15:0] frame_count;
  logic [31:0] stall_cycles;
`endif
  int checks = 0, errors = 0;
  int oidx = 0, fd_cnt = 0, st_x = 0, fl_x = 0, src_cnt = 0;
  logic exp_fd = 0, stall_prev = 0;
  logic [W-1:0] prev_data = '0;
  conv_frame_ctrl_if #(.W(W)) bus();
  conv_frame_ctrl #(.W(W), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BORDER_VALUE(BV)) dut (
    .clk(clk), .reset(reset), .bus(bus.master), .busy(busy), .frame_done(frame_done)
`ifdef CONV_CTRL_STATS_EN
    , .frame_count(frame_count), .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  assign bus.conv_ready = (tog ? phase : 1'b1) && (!bus.res_valid || bus.res_ready);
  always_ff @(posedge clk) phase <= !phase;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.res_valid <= 1'b0;
    else if (bus.conv_valid && bus.conv_ready) begin
      bus.res_valid <= 1'b1;
      bus.res_data <= bus.conv_data;
    end else if (bus.res_ready) bus.res_valid <= 1'b0;
  end
  function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endfunction
  function automatic void tmo(input string n);
    checks++;
    errors++;
    $display("FAIL %s timeout t=%0t", n, $time);
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outs", {bus.src_ready, bus.conv_valid, bus.res_ready, bus.out_valid,
                         bus.out_sof, bus.out_eof, busy, frame_done}, 0);
      oidx = 0; fd_cnt = 0; st_x = 0; fl_x = 0; src_cnt = 0; exp_fd = 0; stall_prev = 0;
    end else begin
      chk("frame_done", frame_done, exp_fd);
      exp_fd = 0;
      if (frame_done) begin fd_cnt++; src_cnt = 0; end
      if (stall_prev) chk("stall_hold", {bus.out_valid, bus.out_data}, {1'b1, prev_data});
      if (bus.src_ready && !bus.conv_ready) chk("src_mirror", 0, 1);
      if (src_cnt == N) chk("src_blocked", bus.src_ready, 0);
      if (bus.conv_valid && bus.conv_ready) begin
        if (bus.src_ready) begin
          st_x++; src_cnt++;
          chk("conv_data", bus.conv_data, bus.src_data);
        end else begin
          fl_x++;
          chk("flush_data", bus.conv_data, 0);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("out%0d", oidx), {bus.out_data, bus.out_sof, bus.out_eof},
            {vec[oidx % N].od, vec[oidx % N].sof, vec[oidx % N].eof});
        if (bus.out_eof) exp_fd = 1;
        oidx++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
  end
  task automatic send(input logic [W-1:0] d);
    int t = 0;
    bus.src_valid = 1;
    bus.src_data = d;
    do begin @(negedge clk); t++; end while (!bus.src_ready && t < 500);
    if (!bus.src_ready) tmo("send");
    @(posedge clk); #1;
  endtask
  task automatic run_frame();
    for (int i = 0; i < N; i++) send(vec[i].px);
  endtask
  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1; bus.src_valid = 0; bus.out_ready = 1; tog = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 0;
  endtask
  task automatic wait_done(input int n);
    int t = 0;
    while ((fd_cnt < n || busy) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) tmo("frame_end");
    chk("frames", fd_cnt, n);
    chk("out_count", oidx, n * N);
    chk("stream_xfers", st_x, n * N);
    chk("flush_xfers", fl_x, n * (WIDTH + 1));
  endtask
  initial begin
    for (int i = 0; i < N; i++) vec[i] = '{px: W'(i + 1), od: BV, sof: i == 0, eof: i == N - 1};
    // (1,1) and (1,2) carry results 11,12: the first five results are discarded.
    vec[5].od = 30'd11;
    vec[6].od = 30'd12;
    bus.src_valid = 0; bus.src_data = '0; bus.out_ready = 1;
    apply_reset();
    run_frame(); bus.src_valid = 0; wait_done(1);
    apply_reset();
    fork
      begin run_frame(); bus.src_valid = 0; end
      begin
        int t = 0;
        while (oidx < 3 && t < 500) begin @(posedge clk); t++; end
        #1 bus.out_ready = 0;
        repeat (10) @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    wait_done(1);
    apply_reset();
    tog = 1;
    run_frame(); bus.src_valid = 0; wait_done(1);
    tog = 0;
    apply_reset();
    run_frame(); run_frame(); bus.src_valid = 0; wait_done(2);
`ifdef CONV_CTRL_STATS_EN
    chk("frame_count2", frame_count, 2);
`endif
    apply_reset();
    for (int i = 0; i < 7; i++) send(vec[i].px);
    reset = 1; bus.src_valid = 0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 0;
    run_frame(); bus.src_valid = 0; wait_done(1);
    apply_reset();
    fork
      begin run_frame(); bus.src_valid = 0; end
      begin
        int t = 0;
        do begin @(negedge clk); t++; end while (!(bus.out_valid && oidx >= 2) && t < 500);
        @(posedge clk); #1 bus.out_ready = 0;
        repeat (20) @(posedge clk);
        #1 bus.out_ready = 1;
`ifdef CONV_CTRL_STATS_EN
        chk("stall_cycles", stall_cycles, 20);
        chk("frame_count_stall", frame_count, 0);
`endif
      end
    join
    wait_done(1);
`ifdef CONV_CTRL_STATS_EN
    chk("frame_count_end", frame_count, 1);
    chk("stall_cycles_end", stall_cycles, 20);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
